// File: rtl/rs_age_issue_queue_pkg.sv
// rtl/rs_age_issue_queue_pkg.sv - shared types and sizing for the age-ordered reservation station
package rs_age_issue_queue_pkg;
    localparam int RS_DEPTH = 8;
    localparam int NUM_CDB  = 2;
    localparam int TAG_W    = 4;
    localparam int XLEN     = 32;
    localparam int AGE_W    = $clog2(RS_DEPTH);
    localparam int CNT_W    = $clog2(RS_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
    } ID_EX_PACKET;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]  value;
    } CDB_DATA;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rs1_tag;
        logic [XLEN-1:0]  rs1_value;
        logic             rs1_ready;
        logic             rs1_need;
        logic [TAG_W-1:0] rs2_tag;
        logic [XLEN-1:0]  rs2_value;
        logic             rs2_ready;
        logic             rs2_need;
        logic [TAG_W-1:0] rd_tag;
        logic [AGE_W-1:0] age;
        logic [31:0]      instr;
    } RS_ENTRY;

    // Returns {hit, value} for the CDB port broadcasting tag this cycle.
    function automatic logic [XLEN:0] cdb_lookup(input CDB_DATA c [NUM_CDB], input logic [TAG_W-1:0] tag);
        cdb_lookup = '0;
        for (int p = 0; p < NUM_CDB; p++)
            if (c[p].valid && c[p].rob_tag == tag)
                cdb_lookup = {1'b1, c[p].value};
    endfunction
endpackage

// File: rtl/rs_age_issue_queue_select.sv
// rtl/rs_age_issue_queue_select.sv - oldest-ready picker: one-hot grant of the maximum-age ready entry
module rs_age_select
    import rs_age_issue_queue_pkg::*;
(
    input  logic [RS_DEPTH-1:0] ready,
    input  logic [AGE_W-1:0]    age [RS_DEPTH],
    output logic [RS_DEPTH-1:0] grant,
    output logic                valid
);
    logic [AGE_W-1:0] best_age;

    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        best_age = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ready[i] && (!valid || age[i] > best_age)) begin
                valid    = 1'b1;
                best_age = age[i];
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_age_issue_queue.sv
// rtl/rs_age_issue_queue.sv - multi-CDB reservation station issuing the oldest ready entry
// Optional: RS_WAKEUP_BYPASS_EN lets a same-cycle CDB broadcast make an entry selectable.
module rs_age_issue_queue
    import rs_age_issue_queue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  ID_EX_PACKET       disp_packet,
    input  logic              disp_need_rs1,
    input  logic              disp_need_rs2,
    input  logic [TAG_W-1:0]  disp_rs1_tag,
    input  logic [TAG_W-1:0]  disp_rs2_tag,
    input  logic              disp_rs1_rdy,
    input  logic              disp_rs2_rdy,
    input  logic [TAG_W-1:0]  disp_rd_tag,
    input  CDB_DATA           cdb [NUM_CDB],
    output logic              iss_valid,
    input  logic              iss_ready,
    output RS_ENTRY           iss_entry,
    output logic [CNT_W-1:0]  rs_count
);
    RS_ENTRY             rs_q [RS_DEPTH];
    RS_ENTRY             new_entry;
    logic [RS_DEPTH-1:0] rdy_sel, grant, free_oh;
    logic [AGE_W-1:0]    ages [RS_DEPTH];
    logic [XLEN:0]       hit1 [RS_DEPTH];
    logic [XLEN:0]       hit2 [RS_DEPTH];
    logic [XLEN:0]       dhit1, dhit2;
    logic                found, disp_fire, iss_fire, cdb_dup;

    always_comb begin
        rs_count = '0;
        free_oh  = '0;
        found    = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            rs_count = rs_count + CNT_W'(rs_q[i].valid);
            if (!rs_q[i].valid && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign disp_ready = (rs_count < CNT_W'(RS_DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_fire   = iss_valid && iss_ready;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            hit1[i] = cdb_lookup(cdb, rs_q[i].rs1_tag);
            hit2[i] = cdb_lookup(cdb, rs_q[i].rs2_tag);
            ages[i] = rs_q[i].age;
`ifdef RS_WAKEUP_BYPASS_EN
            rdy_sel[i] = rs_q[i].valid && (rs_q[i].rs1_ready || hit1[i][XLEN])
                                       && (rs_q[i].rs2_ready || hit2[i][XLEN]);
`else
            rdy_sel[i] = rs_q[i].valid && rs_q[i].rs1_ready && rs_q[i].rs2_ready;
`endif
        end
    end

    rs_age_select u_select (
        .ready (rdy_sel),
        .age   (ages),
        .grant (grant),
        .valid (iss_valid)
    );

    always_comb begin
        iss_entry = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                iss_entry = rs_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
                if (!rs_q[i].rs1_ready) begin
                    iss_entry.rs1_value = hit1[i][XLEN-1:0];
                    iss_entry.rs1_ready = 1'b1;
                end
                if (!rs_q[i].rs2_ready) begin
                    iss_entry.rs2_value = hit2[i][XLEN-1:0];
                    iss_entry.rs2_ready = 1'b1;
                end
`endif
            end
        end
    end

    // A dispatched operand is captured from the CDB only when it is genuinely still pending.
    always_comb begin
        dhit1     = cdb_lookup(cdb, disp_rs1_tag);
        dhit2     = cdb_lookup(cdb, disp_rs2_tag);
        new_entry = '0;
        new_entry.valid     = 1'b1;
        new_entry.rs1_need  = disp_need_rs1;
        new_entry.rs1_tag   = disp_rs1_tag;
        new_entry.rs1_ready = !disp_need_rs1 || disp_rs1_tag == '0 || disp_rs1_rdy || dhit1[XLEN];
        new_entry.rs1_value = (disp_need_rs1 && disp_rs1_tag != '0 && !disp_rs1_rdy && dhit1[XLEN])
                              ? dhit1[XLEN-1:0] : disp_packet.rs1_value;
        new_entry.rs2_need  = disp_need_rs2;
        new_entry.rs2_tag   = disp_rs2_tag;
        new_entry.rs2_ready = !disp_need_rs2 || disp_rs2_tag == '0 || disp_rs2_rdy || dhit2[XLEN];
        new_entry.rs2_value = (disp_need_rs2 && disp_rs2_tag != '0 && !disp_rs2_rdy && dhit2[XLEN])
                              ? dhit2[XLEN-1:0] : disp_packet.rs2_value;
        new_entry.rd_tag    = disp_rd_tag;
        new_entry.instr     = disp_packet.inst;
    end

    // Age counts younger valid entries: dispatch adds one, issuing a younger entry removes one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (disp_fire && free_oh[i]) begin
                    rs_q[i] <= new_entry;
                end else if (rs_q[i].valid) begin
                    if (iss_fire && grant[i]) begin
                        rs_q[i] <= '0;
                    end else begin
                        rs_q[i].age <= rs_q[i].age + AGE_W'(disp_fire)
                                       - AGE_W'(iss_fire && rs_q[i].age > iss_entry.age);
                        if (!rs_q[i].rs1_ready && hit1[i][XLEN]) begin
                            rs_q[i].rs1_value <= hit1[i][XLEN-1:0];
                            rs_q[i].rs1_ready <= 1'b1;
                        end
                        if (!rs_q[i].rs2_ready && hit2[i][XLEN]) begin
                            rs_q[i].rs2_value <= hit2[i][XLEN-1:0];
                            rs_q[i].rs2_ready <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int a = 0; a < NUM_CDB; a++)
            for (int b = a + 1; b < NUM_CDB; b++)
                if (cdb[a].valid && cdb[b].valid && cdb[a].rob_tag == cdb[b].rob_tag)
                    cdb_dup = 1'b1;
    end

    cdb_tag_unique: assert property (@(posedge clk) disable iff (reset) !cdb_dup);
endmodule

// File: tb/tb_rs_age_issue_queue.sv
// tb/tb_rs_age_issue_queue.sv - directed and random checks of rs_age_issue_queue against a queue model
module tb_rs_age_issue_queue;
    import rs_age_issue_queue_pkg::*;

    logic             clk = 1'b0;
    logic             reset, flush, disp_valid, disp_ready;
    ID_EX_PACKET      disp_packet;
    logic             disp_need_rs1, disp_need_rs2, disp_rs1_rdy, disp_rs2_rdy;
    logic [TAG_W-1:0] disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
    CDB_DATA          cdb [NUM_CDB];
    logic             iss_valid, iss_ready;
    RS_ENTRY          iss_entry;
    logic [CNT_W-1:0] rs_count;

    always #5 clk = ~clk;

    rs_age_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_packet(disp_packet),
        .disp_need_rs1(disp_need_rs1), .disp_need_rs2(disp_need_rs2),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rd_tag(disp_rd_tag), .cdb(cdb),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_entry(iss_entry), .rs_count(rs_count)
    );

    typedef struct {
        logic [TAG_W-1:0] t1, t2, rd;
        logic             r1, r2;
        logic [XLEN-1:0]  v1, v2;
        logic [31:0]      inst;
    } ref_t;

    ref_t mq[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oldest_ready();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        int  k;
        logic z;
        k = oldest_ready();
        chk("disp_ready", 64'(disp_ready), 64'(mq.size() < RS_DEPTH));
        chk("rs_count", 64'(rs_count), 64'(mq.size()));
        chk("iss_valid", 64'(iss_valid), 64'(k >= 0));
        if (k >= 0) begin
            chk("iss_rd_tag", 64'(iss_entry.rd_tag), 64'(mq[k].rd));
            chk("iss_rs1_value", 64'(iss_entry.rs1_value), 64'(mq[k].v1));
            chk("iss_rs2_value", 64'(iss_entry.rs2_value), 64'(mq[k].v2));
            chk("iss_instr", 64'(iss_entry.instr), 64'(mq[k].inst));
        end else begin
            z = (iss_entry === '0);
            chk("iss_entry_idle", 64'(z), 64'd1);
        end
    endtask

    task automatic model_edge();
        ref_t e;
        int   k;
        bit   full;
        full = (mq.size() >= RS_DEPTH);
        if (flush) begin
            mq.delete();
            return;
        end
        k = oldest_ready();
        if (iss_ready && k >= 0) mq.delete(k);
        foreach (mq[i])
            for (int p = 0; p < NUM_CDB; p++)
                if (cdb[p].valid) begin
                    if (!mq[i].r1 && mq[i].t1 == cdb[p].rob_tag) begin mq[i].r1 = 1; mq[i].v1 = cdb[p].value; end
                    if (!mq[i].r2 && mq[i].t2 == cdb[p].rob_tag) begin mq[i].r2 = 1; mq[i].v2 = cdb[p].value; end
                end
        if (disp_valid && !full) begin
            e.t1 = disp_rs1_tag; e.t2 = disp_rs2_tag; e.rd = disp_rd_tag; e.inst = disp_packet.inst;
            e.r1 = !disp_need_rs1 || disp_rs1_tag == 0 || disp_rs1_rdy;
            e.r2 = !disp_need_rs2 || disp_rs2_tag == 0 || disp_rs2_rdy;
            e.v1 = disp_packet.rs1_value;
            e.v2 = disp_packet.rs2_value;
            for (int p = 0; p < NUM_CDB; p++)
                if (cdb[p].valid) begin
                    if (!e.r1 && e.t1 == cdb[p].rob_tag) begin e.r1 = 1; e.v1 = cdb[p].value; end
                    if (!e.r2 && e.t2 == cdb[p].rob_tag) begin e.r2 = 1; e.v2 = cdb[p].value; end
                end
            mq.push_back(e);
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; flush = 0;
        for (int p = 0; p < NUM_CDB; p++) cdb[p] = '0;
    endtask

    task automatic set_disp(input logic n1, input logic n2, input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                            input logic k1, input logic k2, input logic [TAG_W-1:0] rd,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [31:0] inst);
        disp_valid = 1;
        disp_need_rs1 = n1; disp_need_rs2 = n2;
        disp_rs1_tag = t1; disp_rs2_tag = t2;
        disp_rs1_rdy = k1; disp_rs2_rdy = k2;
        disp_rd_tag = rd;
        disp_packet.rs1_value = a; disp_packet.rs2_value = b; disp_packet.inst = inst;
    endtask

    task automatic set_cdb(input int p, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] v);
        cdb[p].valid = 1; cdb[p].rob_tag = tag; cdb[p].value = v;
    endtask

    initial begin
        reset = 1; iss_ready = 1;
        idle();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 0;
        #2;
        check_outputs();
        #10 reset = 0;
        @(posedge clk); #1;

        // rs1 waits on tag 3, wakes from CDB, issues the cycle after the broadcast
        set_disp(1, 1, 3, 0, 0, 0, 4'd1, 32'h11, 32'h22, 32'h0000_0033);
        step();
        idle(); step();
        set_cdb(0, 3, 32'h55); step();
        idle(); #1;
        chk("A_wake_valid", 64'(iss_valid), 64'd1);
        chk("A_wake_rs1", 64'(iss_entry.rs1_value), 64'h55);
        step();

        // fill to capacity with disp_valid held, then drain in dispatch order
        iss_ready = 0;
        for (int i = 0; i < RS_DEPTH + 1; i++) begin
            set_disp(1, 1, 0, 0, 0, 0, 4'(i + 1), 32'(i * 3), 32'(i * 5), 32'(100 + i));
            step();
        end
        idle(); #1;
        chk("B_full_ready", 64'(disp_ready), 64'd0);
        chk("B_full_count", 64'(rs_count), 64'(RS_DEPTH));
        iss_ready = 1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            chk("B_order", 64'(iss_entry.rd_tag), 64'(i + 1));
            step();
            if (i == 0) chk("B_ready_after_issue", 64'(disp_ready), 64'd1);
        end

        // two waiters woken by both CDB ports in one cycle; older goes first
        set_disp(1, 0, 5, 0, 0, 0, 4'd9, 32'h1, 32'h2, 32'h3); step();
        set_disp(0, 1, 0, 6, 0, 0, 4'd10, 32'h4, 32'h5, 32'h6); step();
        idle(); set_cdb(0, 5, 32'hAAAA); set_cdb(1, 6, 32'hBBBB); step();
        idle(); #1;
        chk("C_older_first", 64'(iss_entry.rd_tag), 64'd9);
        step(); step();

        // backpressure: iss_entry holds on the oldest while iss_ready is low
        iss_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_disp(1, 1, 0, 0, 1, 1, 4'(11 + i), 32'(i), 32'(i), 32'(i)); step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            #1; chk("D_hold_rd", 64'(iss_entry.rd_tag), 64'd11);
            step();
        end
        iss_ready = 1;
        for (int i = 0; i < 3; i++) step();

        // rs2 not consumed: unresolved tag 7 must not block issue
        set_disp(1, 0, 0, 7, 0, 0, 4'd2, 32'h77, 32'h88, 32'h99); step();
        idle(); #1;
        chk("E_no_need_rs2", 64'(iss_valid), 64'd1);
        step();

        // flush with 5 entries and a concurrent dispatch
        iss_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_disp(1, 1, 4'(1 + i), 0, 0, 0, 4'(i), 32'(i), 32'(i), 32'(i)); step();
        end
        set_disp(1, 1, 0, 0, 0, 0, 4'd6, 0, 0, 0); flush = 1; step();
        idle(); #1;
        chk("F_flush_count", 64'(rs_count), 64'd0);
        chk("F_flush_valid", 64'(iss_valid), 64'd0);
        iss_ready = 1;

        // asynchronous reset while a wakeup is pending
        set_disp(1, 1, 4, 0, 0, 0, 4'd3, 32'h5, 32'h6, 32'h7); step();
        idle(); set_cdb(1, 4, 32'hCC); #2;
        reset = 1; mq.delete(); #1;
        chk("G_reset_count", 64'(rs_count), 64'd0);
        chk("G_reset_ready", 64'(disp_ready), 64'd1);
        chk("G_reset_valid", 64'(iss_valid), 64'd0);
        idle();
        @(posedge clk); #2 reset = 0;
        @(posedge clk); #1;

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [TAG_W-1:0] ta, tb2;
            idle();
            iss_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1)
                set_disp(1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 4'($urandom),
                         $urandom, $urandom, $urandom);
            ta = 4'($urandom_range(1, 7));
            tb2 = 4'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 1) set_cdb(0, ta, $urandom);
            if ($urandom_range(0, 1) == 1 && tb2 != ta) set_cdb(1, tb2, $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rs_age_issue_queue.md
Name: rs_age_issue_queue

Overview:
- Parametrised, multi-CDB reservation station between dispatch (decode, map table, ROB allocation) and one functional unit.
- Holds up to RS_DEPTH in-flight instructions and snoops NUM_CDB broadcast buses for operand wakeup.
- Issues the oldest fully-ready entry through a valid/ready handshake.
- Generalises the single-CDB station: per-instruction operand-need flags, wrap-free relative ageing, flush, issue backpressure.

Parameters:
- RS_DEPTH, 8, number of entries (power of two, >=2)
- NUM_CDB, 2, number of CDB broadcast ports snooped per cycle
- TAG_W, 4, ROB tag width; tag 0 means "value from regfile"
- XLEN, 32, operand width
- AGE_W, $clog2(RS_DEPTH), per-entry age counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous squash of all entries (mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available (registered-state based)
- disp_packet  in  ID_EX_PACKET  decoded instruction incl. regfile rs1/rs2 values
- disp_need_rs1  in  1  instruction consumes rs1
- disp_need_rs2  in  1  instruction consumes rs2
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  map-table producer tags
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  map-table tag-ready bits
- disp_rd_tag  in  TAG_W  ROB slot allocated for destination
- cdb  in  CDB_DATA[NUM_CDB]  broadcasts {valid, rob_tag, value}
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  functional unit accepts
- iss_entry  out  RS_ENTRY  issued instruction, rd_tag, both operand values
- rs_count  out  $clog2(RS_DEPTH)+1  occupied entries

Behaviour:
- Reset: all entries invalid, ages 0; disp_ready=1, iss_valid=0, iss_entry='0, rs_count=0.
- Dispatch: accepted on edge when disp_valid && disp_ready. Writes the lowest-index free entry. disp_ready = rs_count < RS_DEPTH, computed from registered state; a same-cycle issue does not free space for that cycle's dispatch.
- Operand ready at dispatch: !need, or tag==0, or map-table rdy, or matching valid CDB in the same cycle. A CDB match captures the CDB value; otherwise the regfile value is used.
- Wakeup: each edge, every valid entry with a not-ready operand compares its tag against all valid CDB ports. On a match it latches the value and sets ready. rs1 and rs2 are checked independently, so both can wake in one cycle. Multiple ports carrying the same tag is illegal (assertion).
- Ageing: new entry age=0. On an accepted dispatch, every other valid entry's age +1. Age is unique among valid entries and never exceeds RS_DEPTH-1, so no wrap occurs.
- Select: among valid entries with both operands ready, pick the maximum age (oldest). iss_valid/iss_entry are combinational from registered state.
- Issue: on iss_valid && iss_ready the selected entry is invalidated at the edge. If iss_ready=0, the entry stays and iss_entry holds stable unless an older entry becomes ready.
- Simultaneous dispatch+issue: both take effect. rs_count is unchanged; ageing still applies to survivors.
- flush: all entries invalid next edge, dispatch and wakeup that cycle discarded, rs_count=0. Reset overrides flush.
- Earliest issue: one cycle after dispatch, or one cycle after the CDB broadcast.

Optional Feature:
- RS_WAKEUP_BYPASS_EN defined: select also treats an entry as ready if a CDB broadcast this cycle matches its last missing tag. iss_entry then muxes in the CDB value, allowing issue in the broadcast cycle (0-cycle wakeup).
- Undefined: readiness comes only from registered bits (1-cycle wakeup latency).

Decomposition:
- Shared package: RS_ENTRY struct {valid, rs1/rs2 tag/value/ready/need, rd_tag, age, instr}, CDB_DATA, the NUM_CDB constant.
- One sub-module, rs_age_select: RS_DEPTH ready/age vectors in, one-hot grant plus valid out (pure combinational tree).

Test Plan:
- Dispatch ADD with tags 3,0 (rs1 not ready), then CDB {tag 3, value 0x55} -> iss_valid next cycle, rs1 value 0x55.
- Fill 8 entries with all-ready operands, disp_valid held -> disp_ready=0, rs_count=8. Issue one -> disp_ready=1 next cycle; issue order matches dispatch order.
- Two entries waiting on tags 5 and 6, both broadcast on CDB ports 0/1 in the same cycle -> both wake; older issues first.
- Hold iss_ready=0 for 4 cycles with 3 ready entries -> iss_entry stable on oldest, nothing freed. Release -> one entry freed per accepting cycle.
- Load with need_rs2=0 and rs2 tag 7 unresolved -> issues without waiting for tag 7.
- 5 entries valid, assert flush with a concurrent dispatch -> rs_count=0, iss_valid=0 next cycle. Assert reset mid-wakeup -> all outputs at reset values immediately.
